// File: rtl/pll_clk_mgr.sv
// PLL lock qualifier and clock-enable generator.
// A synchronised PLL lock must stay high for LOCK_CYC consecutive cycles
// before the downstream reset is released. While running, every channel
// emits a one-cycle enable pulse once per (div+1) cycles.
module pll_clk_mgr #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int LOCK_CYC = 1024,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              pll_lock,
  input  logic              clr_lost,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_val,
  output logic              div_ack,
  output logic [NUM_CH-1:0] ce,
  output logic              rst_out,
  output logic              locked,
  output logic              lock_lost
);

  localparam int SC_W = $clog2(LOCK_CYC + 1);
  localparam logic [SC_W-1:0] LOCK_LAST = SC_W'(LOCK_CYC - 1);
  localparam logic [CH_W:0]   NUM_CH_L  = (CH_W + 1)'(NUM_CH);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic             sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [SC_W-1:0]  stab_q, stab_d;
  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [DIV_W-1:0] div_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q [NUM_CH];
  logic [DIV_W-1:0] cnt_d [NUM_CH];
  logic             div_ack_q, div_ack_d;
  logic             lock_lost_q, lock_lost_d;
  logic             lock_s, run_s, wr_ok_s;
  logic [NUM_CH-1:0] ce_s;

  assign lock_s  = sync2_q;
  assign run_s   = (state_q == ST_RUN);
  assign wr_ok_s = div_wr && ({1'b0, div_ch} < NUM_CH_L);

  // Lock-qualification FSM: stability count must reach LOCK_CYC-1 while lock holds.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_COUNT;
          stab_d  = SC_W'(1);
        end else begin
          stab_d  = '0;
        end
      end
      ST_COUNT: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          stab_d  = '0;
        end else if (stab_q == LOCK_LAST) begin
          state_d = ST_RUN;
          stab_d  = '0;
        end else begin
          stab_d  = stab_q + SC_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          stab_d  = '0;
        end else begin
          stab_d  = stab_q;
        end
      end
      default: begin
        state_d = ST_WAIT;
        stab_d  = '0;
      end
    endcase
  end

  // Sticky loss flag: a RUN exit caused by lock loss beats a simultaneous clear.
  always_comb begin
    if (run_s && !lock_s) begin
      lock_lost_d = 1'b1;
    end else if (clr_lost) begin
      lock_lost_d = 1'b0;
    end else begin
      lock_lost_d = lock_lost_q;
    end
    div_ack_d = wr_ok_s;
  end

  // Per-channel divider: phase counter runs only in RUN; a write reloads div and restarts phase.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ce_s[i] = run_s && (cnt_q[i] == div_q[i]);
      if (!run_s) begin
        cnt_d[i] = '0;
      end else if (ce_s[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
      if (wr_ok_s && (div_ch == CH_W'(i))) begin
        div_d[i] = div_val;
        cnt_d[i] = '0;
      end else begin
        div_d[i] = div_q[i];
      end
    end
  end

  // State, synchroniser and datapath registers.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_WAIT;
      stab_q      <= '0;
      div_ack_q   <= 1'b0;
      lock_lost_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= pll_lock;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      stab_q      <= stab_d;
      div_ack_q   <= div_ack_d;
      lock_lost_q <= lock_lost_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ce        = ce_s;
  assign locked    = run_s;
  assign rst_out   = !run_s;
  assign div_ack   = div_ack_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_clk_mgr.sv
// Scoreboard bench for pll_clk_mgr: a reference model pushes the expected
// outputs for every clock edge; a monitor pops and compares at the falling edge.
module tb_pll_clk_mgr;

  localparam int NCH  = 3;
  localparam int DW   = 4;
  localparam int LCYC = 8;
  localparam int CHW  = 2;

  logic clkin = 1'b0;
  logic reset = 1'b1;
  logic pll_lock = 1'b0, clr_lost = 1'b0, div_wr = 1'b0;
  logic [CHW-1:0] div_ch = '0;
  logic [DW-1:0]  div_val = '0;
  logic div_ack, rst_out, locked, lock_lost;
  logic [NCH-1:0] ce;

  pll_clk_mgr #(.NUM_CH(NCH), .DIV_W(DW), .LOCK_CYC(LCYC)) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .clr_lost(clr_lost),
    .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val), .div_ack(div_ack),
    .ce(ce), .rst_out(rst_out), .locked(locked), .lock_lost(lock_lost)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic           ack;
    logic [NCH-1:0] ce;
    logic           locked;
    logic           rst_out;
    logic           lost;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state: lock history, run flag, per-channel divide and phase anchor.
  bit m_smp[$];
  int m_streak;
  bit m_run, m_lost;
  int m_div [NCH];
  int m_anchor [NCH];
  int m_edge;

  task automatic model_reset();
    m_smp.delete();
    m_streak = 0;
    m_run = 0;
    m_lost = 0;
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = 0;
      m_anchor[i] = 0;
    end
  endtask

  // One rising edge: lock seen by the controller is the value sampled two edges earlier.
  task automatic model_edge(input bit lk, input bit wr, input int ch, input int val, input bit clr);
    bit seen, run_new, ack;
    exp_t e;
    m_edge++;
    seen = (m_smp.size() >= 2) ? m_smp[m_smp.size()-2] : 1'b0;
    m_smp.push_back(lk);
    m_streak = seen ? ((m_streak < LCYC) ? m_streak + 1 : LCYC) : 0;
    run_new = (m_streak >= LCYC);
    if (run_new && !m_run)
      for (int i = 0; i < NCH; i++) m_anchor[i] = m_edge;
    if (m_run && !run_new) m_lost = 1;
    else if (clr) m_lost = 0;
    ack = wr && (ch < NCH);
    if (ack) begin
      m_div[ch] = val;
      m_anchor[ch] = m_edge;
    end
    m_run = run_new;
    e.ack = ack;
    for (int i = 0; i < NCH; i++)
      e.ce[i] = m_run && (((m_edge - m_anchor[i]) % (m_div[i] + 1)) == m_div[i]);
    e.locked = m_run;
    e.rst_out = !m_run;
    e.lost = m_lost;
    exp_q.push_back(e);
  endtask

  task automatic push_reset_rec();
    exp_t e;
    e = '0;
    e.rst_out = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: pop the expected record for the preceding edge and compare every output.
  always @(negedge clkin) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.ack = div_ack; a.ce = ce; a.locked = locked; a.rst_out = rst_out; a.lost = lock_lost;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs edge=%0d got ack=%b ce=%b locked=%b rst_out=%b lost=%b want ack=%b ce=%b locked=%b rst_out=%b lost=%b",
                 m_edge, a.ack, a.ce, a.locked, a.rst_out, a.lost,
                 e.ack, e.ce, e.locked, e.rst_out, e.lost);
      end
    end
  end

  task automatic step(input bit lk, input bit wr, input int ch, input int val, input bit clr);
    pll_lock = lk; div_wr = wr; div_ch = CHW'(ch); div_val = DW'(val); clr_lost = clr;
    @(posedge clkin);
    model_edge(lk, wr, ch, val, clr);
    @(negedge clkin);
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < n; k++) begin
      @(posedge clkin);
      push_reset_rec();
      @(negedge clkin);
    end
    reset = 1'b0;
  endtask

  // Counts edges (the first edge sampling the high lock is edge 1) until locked rises.
  task automatic measure_lock(input string name);
    int k;
    k = 0;
    while (!locked && k < 40) begin
      k++;
      step(1'b1, 1'b0, 0, 0, 1'b0);
    end
    tests++;
    if (k != LCYC + 2) begin
      fails++;
      $display("FAIL %s lock_edges got %0d want %0d", name, k, LCYC + 2);
    end
  endtask

  initial begin
    m_edge = 0;
    model_reset();
    @(negedge clkin);
    hold_reset(3);

    for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 0, 0, 1'b0);

    measure_lock("acquire");

    step(1'b1, 1'b1, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1, 2, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 2, 15, 1'b0);
    for (int k = 0; k < 34; k++) step(1'b1, 1'b0, 0, 0, 1'b0);

    step(1'b1, 1'b1, 3, 7, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    measure_lock("reacquire");
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
      step(pll_lock, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
    end

    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 0, 0, 1'b1);
    measure_lock("pre_reset");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (locked !== 1'b0 || rst_out !== 1'b1 || lock_lost !== 1'b0 || ce !== '0) begin
      fails++;
      $display("FAIL async_reset got locked=%b rst_out=%b lost=%b ce=%b want 0 1 0 000",
               locked, rst_out, lock_lost, ce);
    end
    @(negedge clkin);
    hold_reset(2);
    measure_lock("after_reset");
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 0, 0, 1'b0);

    @(negedge clkin);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
